nco_clkgen: RTL
===============

# nco_clkgen

Multi-channel, runtime-programmable clock generator built from phase accumulators (NCOs), all clocked from `refclk`. It is the parametrised successor to the fixed single-output I2C PLL wrapper. It produces N independent divided clocks plus aligned one-cycle enables at fractional ratios, for example 1.171875 MHz from 50 MHz. It also provides a config handshake and a `locked` indication. It sits between the board reference clock and slow peripherals (I2C, UART, sensor polling), which should consume `tick` as a clock enable rather than `outclk` as a clock.

## Interface
- `NUM_CLOCKS`, default 2: number of output channels, 1..16.
- `ACC_W`, default 32: accumulator/increment width, 8..48.
- `LOCK_CYCLES`, default 64: `refclk` cycles after reset or reconfig before `locked` asserts, ≥1.
- `DEFAULT_INC`, default {NUM_CLOCKS{32'h0600_0000}}: flat NUM_CLOCKS*ACC_W reset increments, channel 0 in the LSBs.
- `refclk`  in  1  sole clock.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config can be accepted.
- `cfg_chan`  in  4  target channel.
- `cfg_inc`  in  ACC_W  new increment (f_out = f_ref·inc/2^ACC_W).
- `cfg_phase`  in  ACC_W  accumulator load value.
- `cfg_err`  out  1  one-cycle pulse: request rejected.
- `outclk`  out  NUM_CLOCKS  ~50% duty divided clocks.
- `tick`  out  NUM_CLOCKS  one-cycle pulse per output period.
- `locked`  out  1  all channels stable.

## Operation
- Reset (rst=1 at an edge) sets:
  - every `acc` to 0 and every `inc` to DEFAULT_INC slice;
  - `outclk`, `tick`, `cfg_ready`, `cfg_err` and `locked` to 0;
  - the lock counter to 0 and the FSM to UNLOCKED.
- Each non-reset cycle, per channel:
  - compute {carry, sum} = acc + inc (ACC_W+1 bits), then acc <= sum;
  - tick <= carry;
  - outclk <= ~sum[ACC_W-1].
  - A tick therefore coincides with the outclk rising edge.
- inc = 0: the channel is stopped. acc holds, outclk holds its last value, and no ticks are produced.
- `cfg_ready` = 1 in every non-reset cycle after the first (registered, reset 0). An accept is `cfg_valid & cfg_ready`.
- Accepted request with cfg_chan < NUM_CLOCKS and cfg_inc[ACC_W-1] = 0:
  - that channel loads acc <= cfg_phase and inc <= cfg_inc;
  - its tick <= 0 and outclk <= ~cfg_phase[ACC_W-1];
  - other channels continue undisturbed.
- Accepted request with cfg_chan ≥ NUM_CLOCKS, or with cfg_inc MSB set (above Nyquist): cfg_err <= 1 for one cycle. No state changes and lock is unaffected.
- Lock FSM, two states:
  - UNLOCKED: the counter increments each cycle. When it reaches LOCK_CYCLES-1, go to LOCKED and set locked <= 1.
  - LOCKED: hold.
  - From either state, a valid accepted config clears the counter and forces UNLOCKED, with locked <= 0 on the next edge. This applies even if the values are identical.
- Back-to-back accepts are allowed, one per cycle. The last accept restarts lock timing.

## Timing
- All outputs are registered, with one cycle of latency from the accumulator update.
- After rst deasserts at edge E:
  - outclk[i] = 1 after E+1 for any inc < 2^(ACC_W-1);
  - first tick after ceil(2^ACC_W/inc) cycles;
  - locked = 1 after edge E+LOCK_CYCLES.
- Config accepted at edge T: new acc/inc are visible at T+1, locked = 0 from T+1, and locked = 1 at T+LOCK_CYCLES.
- Tick spacing is floor or ceil of 2^ACC_W/inc. Long-run rate is exact: over 2^ACC_W/gcd cycles the tick count is exactly inc/gcd.
- rst asserted mid-operation: everything returns to reset values at that edge. A cfg_valid in the same cycle is ignored, with no cfg_err.

## Structure
- Package `nco_clkgen_pkg`:
  - lock FSM state encoding (UNLOCKED = 0, LOCKED = 1);
  - I2C constant `INC_I2C_1M171875_50M = 32'h0600_0000`.
- Sub-module `nco_channel`: one accumulator, inc register, load port, and registered tick/outclk. Instantiate it NUM_CLOCKS times via generate.
- Top level holds the config decode, error check, and lock counter/FSM.

## Test plan
- Defaults (0x06000000, ACC_W = 32), release reset:
  - exactly 3 ticks per 128 refclk cycles on each channel;
  - tick spacing only 42 or 43 cycles;
  - locked rises at cycle 64.
- Config chan 1 with inc 0x8000_0000 → cfg_err pulse, chan 1 unchanged, locked stays 1.
- Config chan 1 with inc 0x4000_0000, phase 0 → tick every 4 cycles, outclk 2 high / 2 low; locked drops next cycle and returns 64 cycles later. Channel 0 is unchanged throughout.
- Config chan 5 with NUM_CLOCKS = 2 → cfg_err, no other effect.
- Config chan 0 with inc 0 → outclk[0] frozen, no ticks for 1000 cycles.
- Assert rst during a cfg_valid burst and while locked → all outputs 0 at the next edge, no cfg_err, and default behaviour resumes after release.

Source files
------------

// File: rtl/nco_clkgen_pkg.sv
// nco_clkgen_pkg: lock FSM encoding and reference increments shared by the NCO clock generator.
package nco_clkgen_pkg;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;
  // 50 MHz * 0x0600_0000 / 2^32 = 1.171875 MHz
  localparam logic [31:0] INC_I2C_1M171875_50M = 32'h0600_0000;
endpackage

// File: rtl/nco_channel.sv
// nco_channel: one phase accumulator with loadable phase/increment and registered tick/outclk.
module nco_channel
  import nco_clkgen_pkg::*;
#(
  parameter int               ACC_W   = 32,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_inc,
  input  logic [ACC_W-1:0] i_phase,
  output logic             o_tick,
  output logic             o_outclk
);
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic             r_tick;
  logic             r_outclk;
  logic [ACC_W:0]   w_sum;
  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
  // the carry out of the wrap is exactly the outclk rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_inc    <= RST_INC;
      r_tick   <= 1'b0;
      r_outclk <= 1'b0;
    end else if (i_load) begin
      r_acc    <= i_phase;
      r_inc    <= i_inc;
      r_tick   <= 1'b0;
      r_outclk <= ~i_phase[ACC_W-1];
    end else begin
      r_acc    <= w_sum[ACC_W-1:0];
      r_tick   <= w_sum[ACC_W];
      r_outclk <= ~w_sum[ACC_W-1];
    end
  end
  assign o_tick   = r_tick;
  assign o_outclk = r_outclk;
endmodule

// File: rtl/nco_clkgen.sv
// nco_clkgen: NUM_CLOCKS runtime-programmable NCO clock/enable generators with config handshake and lock indication.
module nco_clkgen
  import nco_clkgen_pkg::*;
#(
  parameter int                          NUM_CLOCKS  = 2,
  parameter int                          ACC_W       = 32,
  parameter int                          LOCK_CYCLES = 64,
  parameter logic [NUM_CLOCKS*ACC_W-1:0] DEFAULT_INC = {NUM_CLOCKS{INC_I2C_1M171875_50M}}
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [ACC_W-1:0]      cfg_inc,
  input  logic [ACC_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);
  localparam int CW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  lock_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic r_ready, r_err, r_locked;
  logic w_accept, w_good;
  assign w_accept = cfg_valid & r_ready;
  // increments with the MSB set would exceed Nyquist and are rejected
  assign w_good   = w_accept & ({1'b0, cfg_chan} < 5'(NUM_CLOCKS)) & ~cfg_inc[ACC_W-1];
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state  <= UNLOCKED;
      r_cnt    <= '0;
      r_locked <= 1'b0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_accept & ~w_good;
      if (w_good) begin
        r_state  <= UNLOCKED;
        r_cnt    <= '0;
        r_locked <= 1'b0;
      end else if (r_state == UNLOCKED) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(LOCK_CYCLES - 1)) begin
          r_state  <= LOCKED;
          r_locked <= 1'b1;
        end
      end
    end
  end
  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_ch
    nco_channel #(
      .ACC_W  (ACC_W),
      .RST_INC(DEFAULT_INC[g*ACC_W +: ACC_W])
    ) u_ch (
      .clk     (refclk),
      .rst     (rst),
      .i_load  (w_good && cfg_chan == 4'(g)),
      .i_inc   (cfg_inc),
      .i_phase (cfg_phase),
      .o_tick  (tick[g]),
      .o_outclk(outclk[g])
    );
  end
  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;
  assign locked    = r_locked;
endmodule
